// File: rtl/player_input_buffer.sv
// Player text-entry line buffer: turns USB HID keycodes into an ASCII line with a
// blinking cursor, then holds the finished line until the consumer acknowledges it.
module player_input_buffer #(
  parameter int unsigned MAX_LEN   = 30,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [7:0]                       keycode,
  input  logic                             enable,
  input  logic                             line_ack,
  output logic [31:0]                      player_input [0:MAX_LEN],
  output logic [$clog2(MAX_LEN+1)-1:0]     length,
  output logic                             line_valid
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {StEdit, StHold} state_e;

  state_e          state_q;
  logic [7:0]      prev_q;
  logic [7:0]      slots_q [MAX_LEN];
  logic [LenW-1:0] len_q;
  logic [CntW-1:0] cnt_q;
  logic            phase_q;
  logic            valid_q;

  logic       key_evt, is_print, is_enter, is_bksp;
  logic [7:0] ascii;
  logic       gate, do_print, do_bksp, do_enter, do_ack;

  // Keycode classification and ASCII translation.
  always_comb begin
    is_print = 1'b0;
    is_enter = 1'b0;
    is_bksp  = 1'b0;
    ascii    = 8'd0;
    if (keycode >= 8'h04 && keycode <= 8'h1D) begin
      is_print = 1'b1;
      ascii    = keycode + 8'd61;
    end else if (keycode >= 8'h1E && keycode <= 8'h26) begin
      is_print = 1'b1;
      ascii    = keycode + 8'd19;
    end else if (keycode == 8'h27) begin
      is_print = 1'b1;
      ascii    = 8'd48;
    end else if (keycode == 8'h2C) begin
      is_print = 1'b1;
      ascii    = 8'd32;
    end else if (keycode == 8'h28) begin
      is_enter = 1'b1;
    end else if (keycode == 8'h2A) begin
      is_bksp = 1'b1;
    end
  end

  // Edge-detected key events, qualified by state, enable and fill level.
  always_comb begin
    key_evt  = (keycode != 8'd0) && (keycode != prev_q);
    gate     = (state_q == StEdit) && enable && key_evt;
    do_print = gate && is_print && (len_q < LenW'(MAX_LEN));
    do_bksp  = gate && is_bksp && (len_q != '0);
    do_enter = gate && is_enter && (len_q != '0);
    do_ack   = (state_q == StHold) && line_ack;
  end

  // Edit/hold FSM with line storage, blink timer and registered status.
  always_ff @(posedge Clk) begin
    prev_q <= keycode;
    if (Reset) begin
      state_q <= StEdit;
      prev_q  <= 8'd0;
      for (int unsigned i = 0; i < MAX_LEN; i++) slots_q[i] <= 8'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEdit: begin
          if (do_print) begin
            slots_q[len_q] <= ascii;
            len_q          <= len_q + 1'b1;
          end else if (do_bksp) begin
            slots_q[len_q - 1'b1] <= 8'd0;
            len_q                 <= len_q - 1'b1;
          end else if (do_enter) begin
            state_q <= StHold;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (do_ack) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) slots_q[i] <= 8'd0;
            len_q   <= '0;
            valid_q <= 1'b0;
            state_q <= StEdit;
          end
        end
        default: state_q <= StEdit;
      endcase

      // Any accepted key (or a fresh line) restarts the cursor visible.
      if (do_print || do_bksp || do_enter || do_ack) begin
        cnt_q   <= '0;
        phase_q <= 1'b1;
      end else if (state_q == StEdit) begin
        if (cnt_q == CntW'(BLINK_DIV - 1)) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Display row: stored characters below length, cursor at length, zeros above.
  always_comb begin
    for (int unsigned i = 0; i <= MAX_LEN; i++) player_input[i] = 32'd0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LenW'(i) < len_q) player_input[i] = {24'd0, slots_q[i]};
    end
    if (state_q == StEdit && phase_q) player_input[len_q] = 32'd95;
  end

  assign length     = len_q;
  assign line_valid = valid_q;

endmodule

// File: tb/tb_player_input_buffer.sv
// Scoreboard bench for player_input_buffer: stimulus pushes expected values,
// a negedge monitor pops and compares them against the outputs.
module tb_player_input_buffer;

  localparam int unsigned MaxLen = 30;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'd0;
  logic        enable = 1'b1;
  logic        line_ack = 1'b0;
  logic [31:0] player_input [0:MaxLen];
  logic [4:0]  length;
  logic        line_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    kind;  // 0 slot, 1 length, 2 line_valid
    int    idx;
    int    val;
  } exp_t;

  exp_t sb[$];

  player_input_buffer #(
    .MAX_LEN  (MaxLen),
    .BLINK_DIV(4)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .enable      (enable),
    .line_ack    (line_ack),
    .player_input(player_input),
    .length      (length),
    .line_valid  (line_valid)
  );

  always #5 Clk = ~Clk;

  // One clock: drive at negedge, return just after the sampling edge.
  task automatic cyc(input logic [7:0] kc, input logic ack, input logic rst);
    @(negedge Clk);
    keycode  = kc;
    line_ack = ack;
    Reset    = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_slot(input string name, input int idx, input int val);
    exp_t e;
    e.name = name; e.kind = 0; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_len(input string name, input int val);
    exp_t e;
    e.name = name; e.kind = 1; e.idx = 0; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_valid(input string name, input int val);
    exp_t e;
    e.name = name; e.kind = 2; e.idx = 0; e.val = val;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    cyc(8'd0, 1'b0, 1'b1);
    cyc(8'd0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every pending expectation against the settled outputs.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = int'(player_input[e.idx]);
          1:       act = int'(length);
          default: act = int'(line_valid);
        endcase
        checks++;
        if (act != e.val) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    enable = 1'b1;

    // Reset values
    do_reset();
    exp_len("rst_len", 0);
    exp_valid("rst_valid", 0);
    exp_slot("rst_cursor", 0, 95);
    exp_slot("rst_slot1", 1, 0);

    // Typing 'T','R'
    cyc(8'h17, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h15, 1'b0, 1'b0);
    exp_slot("type_s0", 0, 84);
    exp_slot("type_s1", 1, 82);
    exp_slot("type_cursor", 2, 95);
    exp_len("type_len", 2);
    // line_ack has no effect while editing
    cyc(8'h00, 1'b1, 1'b0);
    exp_len("ack_edit_len", 2);
    exp_slot("ack_edit_s1", 1, 82);
    exp_valid("ack_edit_valid", 0);

    // Held key repeats once
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'h04, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    exp_slot("hold_s0", 0, 65);
    exp_len("hold_len", 1);
    exp_slot("hold_s2", 2, 0);

    // Fill to capacity, overflow ignored, then backspace
    do_reset();
    for (int i = 0; i < 31; i++) begin
      if (i > 0) cyc(8'h00, 1'b0, 1'b0);
      cyc(8'(8'h04 + (i % 26)), 1'b0, 1'b0);
    end
    exp_len("full_len", 30);
    exp_slot("full_s29", 29, 68);
    exp_slot("full_cursor", 30, 95);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h2A, 1'b0, 1'b0);
    exp_len("bksp_len", 29);
    exp_slot("bksp_cursor", 29, 95);
    exp_slot("bksp_s30", 30, 0);
    exp_slot("bksp_s28", 28, 67);

    // Enter and handshake
    do_reset();
    cyc(8'h28, 1'b0, 1'b0);
    exp_len("enter0_len", 0);
    exp_valid("enter0_valid", 0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h22, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h28, 1'b0, 1'b0);
    exp_valid("enter_valid", 1);
    exp_len("enter_len", 1);
    exp_slot("enter_s0", 0, 53);
    exp_slot("enter_nocursor", 1, 0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h04, 1'b0, 1'b0);
    exp_len("holdkey_len", 1);
    exp_slot("holdkey_s1", 1, 0);
    cyc(8'h00, 1'b1, 1'b0);
    exp_len("ack_len", 0);
    exp_valid("ack_valid", 0);
    exp_slot("ack_s0", 0, 95);
    exp_slot("ack_s1", 1, 0);
    cyc(8'h00, 1'b0, 1'b0);

    // Reset during hold beats a simultaneous key
    cyc(8'h22, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h28, 1'b0, 1'b0);
    exp_valid("pre_rst_valid", 1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h04, 1'b1, 1'b1);
    exp_len("rsthold_len", 0);
    exp_valid("rsthold_valid", 0);
    exp_slot("rsthold_s0", 0, 95);
    exp_slot("rsthold_s1", 1, 0);

    // Enable low: events dropped, held key gives nothing on enable rise
    do_reset();
    enable = 1'b0;
    cyc(8'h04, 1'b0, 1'b0);
    exp_len("dis_len", 0);
    enable = 1'b1;
    cyc(8'h04, 1'b0, 1'b0);
    exp_len("dis_rise_len", 0);
    exp_slot("dis_rise_s1", 1, 0);

    // Blink: 4 cycles visible, 4 hidden; a keypress restarts visible
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      cyc(8'h00, 1'b0, 1'b0);
      exp_slot($sformatf("blink_k%0d", k), 0, (((k / 4) % 2) == 0) ? 95 : 0);
    end
    cyc(8'h04, 1'b0, 1'b0);
    exp_slot("blink_key_s0", 0, 65);
    exp_slot("blink_restart", 1, 95);
    exp_len("blink_len", 1);

    cyc(8'h00, 1'b0, 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_input_buffer.md
PLAYER_INPUT_BUFFER -- requirements
Module: player_input_buffer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 30: maximum stored characters; slot MAX_LEN is reserved for the cursor.
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000: Clk cycles per cursor blink phase.
REQ-003 SHALL have port Clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port keycode, input, 8 bits: current USB HID keycode; 0 means no key.
REQ-006 SHALL have port enable, input, 1 bit: when high, key events are accepted.
REQ-007 SHALL have port line_ack, input, 1 bit: consumer accepts the held line.
REQ-008 SHALL have port player_input, output, int array [0:30], 32 bits each: ASCII codes, 0 = blank; drives the text-overlay input row.
REQ-009 SHALL have port length, output, 5 bits: number of stored characters.
REQ-010 SHALL have port line_valid, output, 1 bit: a completed line is held for the consumer.

Function
REQ-011 SHALL register keycode into prev_keycode every cycle.
REQ-012 SHALL define a key event as keycode != 0 and keycode != prev_keycode.
  - A held key SHALL produce exactly one event.
  - A direct change from key A to key B SHALL produce one event, for B.
REQ-013 SHALL map keycodes to ASCII as follows; all other keycodes are ignored.
  - 0x04-0x1D -> 65-90 ('A'-'Z').
  - 0x1E-0x26 -> 49-57 ('1'-'9').
  - 0x27 -> 48 ('0').
  - 0x2C -> 32 (space).
  - 0x28 -> Enter.
  - 0x2A -> Backspace.
REQ-014 SHALL implement two states, EDIT and HOLD; Reset enters EDIT.
REQ-015 In EDIT, on a printable event with enable=1 and length < MAX_LEN: slot[length] <= ASCII and length <= length+1, on the same edge the event is sampled (1-cycle latency to outputs).
REQ-016 In EDIT with length == MAX_LEN, printable events SHALL be ignored; contents unchanged.
REQ-017 In EDIT, on a Backspace event with length > 0: slot[length-1] <= 0 and length <= length-1; with length == 0, ignore.
REQ-018 In EDIT, on an Enter event with length > 0: go to HOLD and set line_valid to 1 on the same edge; with length == 0, ignore.
REQ-019 With enable=0, all events SHALL be ignored; prev_keycode SHALL still track keycode, so a key held across the enable rise produces no event.
REQ-020 In HOLD, all key events SHALL be ignored, the cursor SHALL be hidden, and slot contents and length SHALL be stable.
REQ-021 In HOLD, when line_ack is sampled 1, on that edge:
  - all slots <= 0
  - length <= 0
  - line_valid <= 0
  - state <= EDIT
REQ-022 line_ack SHALL be ignored in EDIT.
REQ-023 In EDIT, the blink counter SHALL count 0..BLINK_DIV-1 and toggle cursor_phase on wrap.
REQ-024 On any accepted event, the blink counter SHALL be reset to 0 and cursor_phase set to 1.
REQ-025 The cursor SHALL be displayed in player_input[length] as 95 ('_') when state == EDIT and cursor_phase == 1; otherwise that slot SHALL read its stored value (0).
REQ-026 Slots above the cursor position SHALL always read 0.
REQ-027 All outputs SHALL be registered or derived only from registered state; there SHALL be no combinational path from keycode to outputs.

Reset
REQ-028 On Reset=1 at a rising edge, regardless of state (including mid-HOLD, which discards the line):
  - all slots = 0
  - length = 0
  - line_valid = 0
  - state = EDIT
  - prev_keycode = 0
  - blink counter = 0
  - cursor_phase = 1
REQ-029 Reset SHALL take priority over any simultaneous key event or line_ack.

Verification (BLINK_DIV = 4 in the bench)
REQ-030 Typing test: with enable=1, keycode sequence 0x17, 0, 0x15, 0 ('T', 'R') -> player_input[0]=84, [1]=82, [2]=95 while cursor_phase=1, length=2.
REQ-031 Hold-repeat test: keycode held at 0x04 for 10 cycles -> exactly one 'A' (65) stored, length=1.
REQ-032 Full/backspace test:
  - 31 alternating letter/0 presses -> length=30, slot[29] is the 30th letter, slot[30]=95, 31st ignored.
  - Then 0x2A -> length=29, slot[29]=95.
REQ-033 Enter/handshake test:
  - Enter at length 0 -> no change.
  - After typing "5" (0x22), Enter -> line_valid=1, slot[1]=0 (no cursor), further keys ignored.
  - line_ack=1 for 1 cycle -> next cycle all slots 0, length=0, line_valid=0.
REQ-034 Reset-in-HOLD test: Reset asserted while line_valid=1, with keycode=0x04 changing on the same edge -> all outputs at reset values, no 'A' stored.
REQ-035 Blink test: idle in EDIT with length=0 -> slot[0] alternates between 95 and 0 every 4 cycles; a keypress restarts the phase at visible.
